// File: rtl/mem_slave.sv
// Handshaked single-port memory slave with per-word written flags and range error.
// Optional MEM_RD_REG_EN adds a WAIT state and a second read register (2-cycle latency).
module mem_slave #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 200
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    input  logic                  wr_rd,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    output logic                  ready,
    output logic [WIDTH-1:0]      rdata,
    output logic                  err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [ADDR_WIDTH:0] DEPTH_L = DEPTH[ADDR_WIDTH:0];

    state_e             state_q, state_d;
    logic               ready_q, ready_d;
    logic [WIDTH-1:0]   rdata_q, rdata_d;
    logic               err_q, err_d;
    logic [DEPTH-1:0]   wr_flag_q, wr_flag_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic               accept_s;
    logic               in_range_s;
    logic               mem_we_s;
    logic [WIDTH-1:0]   rd_word_s;
`ifdef MEM_RD_REG_EN
    logic [WIDTH-1:0]   rd_pipe_q, rd_pipe_d;
    logic               err_pipe_q, err_pipe_d;
`endif

    // Request decode; unwritten words and out-of-range reads return zero, never X
    always_comb begin
        accept_s   = (state_q == ST_IDLE) && valid;
        in_range_s = ({1'b0, addr} < DEPTH_L);
        mem_we_s   = rst && accept_s && wr_rd && in_range_s;
        if (in_range_s && !wr_rd && wr_flag_q[addr]) begin
            rd_word_s = mem_q[addr];
        end else begin
            rd_word_s = '0;
        end
    end

    // Written-flag update
    always_comb begin
        wr_flag_d = wr_flag_q;
        if (mem_we_s) begin
            wr_flag_d[addr] = 1'b1;
        end else begin
            wr_flag_d = wr_flag_q;
        end
    end

    // Storage array, deliberately not reset
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[addr] <= wdata;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: begin
                if (valid) begin
`ifdef MEM_RD_REG_EN
                    state_d = ST_WAIT;
`else
                    state_d = ST_RESP;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
`ifdef MEM_RD_REG_EN
            ST_WAIT: state_d = ST_RESP;
`endif
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output/pipeline next values: outputs are nonzero only while the FSM sits in RESP
    always_comb begin
        ready_d = 1'b0;
        rdata_d = '0;
        err_d   = 1'b0;
`ifdef MEM_RD_REG_EN
        rd_pipe_d  = '0;
        err_pipe_d = 1'b0;
        if (accept_s) begin
            rd_pipe_d  = rd_word_s;
            err_pipe_d = !in_range_s;
        end else if (state_q == ST_WAIT) begin
            ready_d = 1'b1;
            rdata_d = rd_pipe_q;
            err_d   = err_pipe_q;
        end else begin
            ready_d = 1'b0;
        end
`else
        if (accept_s) begin
            ready_d = 1'b1;
            rdata_d = rd_word_s;
            err_d   = !in_range_s;
        end else begin
            ready_d = 1'b0;
        end
`endif
    end

    // State, flags and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            ready_q    <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            wr_flag_q  <= '0;
`ifdef MEM_RD_REG_EN
            rd_pipe_q  <= '0;
            err_pipe_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            wr_flag_q  <= wr_flag_d;
`ifdef MEM_RD_REG_EN
            rd_pipe_q  <= rd_pipe_d;
            err_pipe_q <= err_pipe_d;
`endif
        end
    end

    assign ready = ready_q;
    assign rdata = rdata_q;
    assign err   = err_q;

endmodule
